mskmux_buf: RTL and testbench
=============================

# mskmux_buf

Registered, flow-controlled N-way masked multiplexer with a non-sensitive binary select. It selects one of `n_in` sharings of `count` masked bits with `d` shares each and delivers it through a 2-entry skid buffer with valid/ready handshakes. It is the pipelined, multi-input successor of the combinational 2-input masked mux. It sits between masked datapath stages that need back-pressure, for example key/state source selection ahead of S-box pipelines.

## Interface
- `d`, 1: number of shares per bit (masking order + 1); ≥1.
- `count`, 1: number of masked bits per sharing; ≥1.
- `n_in`, 4: number of input sharings; ≥2.
- `CLEAR`, 1: when 1, vacated buffer entries are zeroed; when 0, data registers hold stale values.
- `SEL_W`, derived as `max(1, clog2(n_in))`; not overridable.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sharing and select are valid.
- `in_ready`  out  1  block can accept an input this cycle.
- `in_sel`  in  SEL_W  non-sensitive control; index of the selected sharing.
- `in_data`  in  n_in·count·d  sharing `i` occupies bits `[(i+1)·count·d-1 : i·count·d]`; share layout within each sharing is unchanged from the codebase's sharing convention.
- `out_valid`  out  1  `out_data` holds a valid sharing.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  count·d  selected sharing.
- `out_err`  out  1  entry at head was accepted with `in_sel ≥ n_in`.

## Operation
- Accept when `in_valid & in_ready`. The selected sharing is `in_data` slice `in_sel`, captured share-wise with no recombination or XOR across shares.
- If `in_sel ≥ n_in`:
  - the captured data is all-zero, which is a valid sharing of 0;
  - the entry's err bit is set.
- Pop when `out_valid & out_ready`.
- Storage is two entries, each holding data and err:
  - main: drives `out_data`/`out_err`;
  - skid.
- Occupancy `occ` ∈ {0,1,2}. `out_valid = (occ ≥ 1)`. `in_ready = (occ < 2)`; it is a registered flag, never combinationally dependent on `out_ready`.
- Transitions:
  - occ 0, push: main ← new; occ 1.
  - occ 1, push only: skid ← new; occ 2.
  - occ 1, pop only: occ 0.
  - occ 1, push & pop: main ← new; occ 1.
  - occ 2, pop: main ← skid; occ 1. No push is possible because `in_ready` = 0.
  - No event: all registers hold.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- With `CLEAR=1`, any entry that becomes empty has its data and err zeroed in the same edge:
  - main on a pop to occ 0;
  - skid on `main ← skid`.
- `out_data` is 0 whenever `out_valid` = 0 (CLEAR=1 only).
- Select decode uses only `in_sel`. No share of any input is combined with a share of another input or another share index.
- Reset (`rst_n` low, asynchronous): `occ` = 0, main = 0, skid = 0, err bits = 0. This gives `in_ready` = 0 during reset.
- First edge after deassertion: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_err` = 0.
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

## Timing
- Latency: an input accepted at edge t is visible on `out_data` with `out_valid` = 1 after edge t, assuming occ was 0 or a simultaneous pop occurred.
- Throughput is 1 sharing/cycle with `out_ready` held high.
- `in_ready` drops in the cycle after occ reaches 2. It rises on the edge following the pop that leaves occ = 1.
- Outputs are driven from registers only; there is no combinational in→out path. This keeps glitch-free, probe-isolated boundaries.
- `out_data` must stay stable while `out_valid & !out_ready`.

## Test plan
- Reset and idle:
  - hold `rst_n` = 0 for 3 cycles, then release → `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_err` = 0;
  - assert `rst_n` low asynchronously with occ = 2 → all outputs 0 before the next edge.
- Basic select (d=2, count=4, n_in=4):
  - drive sharings 0x11, 0x22, 0x33, 0x44 with `in_sel` = 2 and `out_ready` = 1 → next cycle `out_data` = 0x33, `out_valid` = 1;
  - streaming `in_sel` 0,1,2,3 on consecutive cycles → outputs 0x11, 0x22, 0x33, 0x44 back-to-back.
- Back-pressure:
  - `out_ready` = 0, push A then B → `in_ready` = 0 after the second accept and `out_data` = A stable;
  - raise `out_ready` → A, then B on successive cycles; `in_ready` returns to 1.
- Simultaneous push/pop at occ 1 → occ stays 1, `out_data` updates to the new entry, and no bubble appears.
- Out-of-range select (n_in = 3, `in_sel` = 3) → `out_data` = 0 and `out_err` = 1 for that entry only; the neighbouring entries show `out_err` = 0.
- CLEAR check (CLEAR = 1) → after the last pop, `out_data` and skid contents are 0.
- Random stress: random valid/ready → scoreboard matches FIFO order. Additionally, the recombined XOR of shares equals the reference select.

Source files
------------

// File: rtl/mskmux_buf.sv
// mskmux_buf: registered N-way masked mux with non-sensitive select feeding a 2-entry skid buffer
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is a registered flag
//   in_sel                binary select (non-sensitive), out-of-range selects capture zero and flag err
//   in_data               n_in sharings of count*d bits, sharing i at [(i+1)*count*d-1 : i*count*d]
//   out_valid/out_ready   output handshake
//   out_data, out_err     head entry data and out-of-range flag, driven from registers
module mskmux_buf #(
  parameter int d = 1,
  parameter int count = 1,
  parameter int n_in = 4,
  parameter bit CLEAR = 1'b1,
  localparam int SEL_W = ($clog2(n_in) > 0) ? $clog2(n_in) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [n_in*count*d-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [count*d-1:0]        out_data,
  output logic                      out_err
);
  localparam int W = count * d;
  logic [W-1:0] slices [n_in];
  logic [W:0] main_q, skid_q, main_n, skid_n, new_e;
  logic [1:0] occ, occ_n;
  logic rdy, push, pop, sel_ok, ld_main, ld_skid, mv, clr_main;
  for (genvar i = 0; i < n_in; i++) begin : g_slice
    assign slices[i] = in_data[i*W +: W];
  end
  // Shares are moved as whole bit-vectors; the select only gates which slice is taken.
  assign sel_ok = 32'(in_sel) < n_in;
  assign new_e = sel_ok ? {1'b0, slices[in_sel]} : {1'b1, {W{1'b0}}};
  assign push = in_valid & rdy;
  assign pop = out_valid & out_ready;
  assign ld_main = push & ((occ == 2'd0) | pop);
  assign ld_skid = push & ~pop & (occ == 2'd1);
  assign mv = pop & (occ == 2'd2);
  assign clr_main = pop & ~push & (occ == 2'd1);
  always_comb begin
    main_n = ld_main ? new_e : mv ? skid_q : (clr_main && CLEAR) ? '0 : main_q;
    skid_n = ld_skid ? new_e : (mv && CLEAR) ? '0 : skid_q;
    occ_n = occ + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      main_q <= '0;
      skid_q <= '0;
      rdy <= 1'b0;
    end else begin
      occ <= occ_n;
      main_q <= main_n;
      skid_q <= skid_n;
      rdy <= occ_n != 2'd2;
    end
  end
  assign in_ready = rdy;
  assign out_valid = occ != 2'd0;
  assign out_data = main_q[W-1:0];
  assign out_err = main_q[W];
endmodule

// File: tb/tb_mskmux_buf.sv
// tb_mskmux_buf: directed and random checks of mskmux_buf with immediate assertions
module tb_mskmux_buf;
  logic clk = 1'b0;
  logic rst_n;
  logic v4, r4, ir4, ov4, oe4;
  logic [1:0] sel4;
  logic [31:0] din4;
  logic [7:0] od4;
  logic v3, r3, ir3, ov3, oe3;
  logic [1:0] sel3;
  logic [23:0] din3;
  logic [7:0] od3;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q [$];
  logic [7:0] exp_d;
  logic push, pop;

  always #5 clk = ~clk;

  mskmux_buf #(.d(2), .count(4), .n_in(4), .CLEAR(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_sel(sel4),
    .in_data(din4), .out_valid(ov4), .out_ready(r4), .out_data(od4), .out_err(oe4)
  );

  mskmux_buf #(.d(2), .count(4), .n_in(3), .CLEAR(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .in_sel(sel3),
    .in_data(din3), .out_valid(ov3), .out_ready(r3), .out_data(od3), .out_err(oe3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] recomb(input logic [7:0] v);
    logic [3:0] x = '0;
    for (int s = 0; s < 2; s++) x ^= v[s*4 +: 4];
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    {v4, r4, sel4, din4, v3, r3, sel3, din3} = '0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(ir4), 0);
    chk("rst_out_valid", 64'(ov4), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 64'(ir4), 1);
    chk("idle_out_valid", 64'(ov4), 0);
    chk("idle_out_data", 64'(od4), 0);
    chk("idle_out_err", 64'(oe4), 0);

    din4 = 32'h4433_2211;
    sel4 = 2'd2; v4 = 1'b1; r4 = 1'b1;
    tick();
    chk("sel2_valid", 64'(ov4), 1);
    chk("sel2_data", 64'(od4), 64'h33);
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      tick();
      chk("stream_data", 64'(od4), 64'(8'h11 * (i + 1)));
      chk("stream_valid", 64'(ov4), 1);
      chk("stream_ready", 64'(ir4), 1);
    end
    v4 = 1'b0;
    tick();
    chk("drain_valid", 64'(ov4), 0);
    chk("drain_clear", 64'(od4), 0);

    r4 = 1'b0; v4 = 1'b1; sel4 = 2'd0;
    tick();
    chk("bp_a_data", 64'(od4), 64'h11);
    chk("bp_a_ready", 64'(ir4), 1);
    sel4 = 2'd1;
    tick();
    chk("bp_full_ready", 64'(ir4), 0);
    chk("bp_full_data", 64'(od4), 64'h11);
    v4 = 1'b0;
    tick();
    chk("bp_stable", 64'(od4), 64'h11);
    r4 = 1'b1;
    tick();
    chk("bp_pop_b", 64'(od4), 64'h22);
    chk("bp_ready_back", 64'(ir4), 1);
    tick();
    chk("bp_empty_valid", 64'(ov4), 0);
    chk("bp_empty_data", 64'(od4), 0);
    chk("bp_empty_err", 64'(oe4), 0);

    r4 = 1'b0; v4 = 1'b1; sel4 = 2'd3;
    tick();
    sel4 = 2'd2;
    tick();
    chk("pre_arst_full", 64'(ir4), 0);
    v4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov4), 0);
    chk("arst_data", 64'(od4), 0);
    chk("arst_ready", 64'(ir4), 0);
    chk("arst_err", 64'(oe4), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_arst_ready", 64'(ir4), 1);

    din3 = 24'h77_66_55;
    r3 = 1'b1; v3 = 1'b1; sel3 = 2'd0;
    tick();
    chk("oor_prev_data", 64'(od3), 64'h55);
    chk("oor_prev_err", 64'(oe3), 0);
    sel3 = 2'd3;
    tick();
    chk("oor_data", 64'(od3), 0);
    chk("oor_err", 64'(oe3), 1);
    chk("oor_valid", 64'(ov3), 1);
    sel3 = 2'd1;
    tick();
    chk("oor_next_data", 64'(od3), 64'h66);
    chk("oor_next_err", 64'(oe3), 0);
    v3 = 1'b0;
    tick();
    chk("oor_clear_err", 64'(oe3), 0);

    for (int c = 0; c < 400; c++) begin
      v4 = c < 360 ? 1'($urandom_range(0, 1)) : 1'b0;
      r4 = 1'($urandom_range(0, 2) != 0);
      sel4 = 2'($urandom_range(0, 3));
      din4 = $urandom;
      chk("rnd_ready", 64'(ir4), 64'(q.size() < 2));
      chk("rnd_valid", 64'(ov4), 64'(q.size() != 0));
      push = v4 && ir4;
      pop = ov4 && r4;
      if (q.size() == 0) chk("rnd_idle_zero", 64'(od4), 0);
      if (pop && q.size() != 0) begin
        exp_d = q.pop_front();
        chk("rnd_fifo", 64'(od4), 64'(exp_d));
        chk("rnd_recomb", 64'(recomb(od4)), 64'(recomb(exp_d)));
        chk("rnd_err", 64'(oe4), 0);
      end
      if (push) q.push_back(din4[sel4*8 +: 8]);
      tick();
    end
    chk("rnd_drained", 64'(q.size()), 0);
    chk("rnd_end_valid", 64'(ov4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
